// File: rtl/oram_host_ctrl_pkg.sv
// rtl/oram_host_ctrl_pkg.sv - ORAM geometry, host controller state and request types
package oramPkg;

  localparam int BYTE_WIDTH      = 8;
  localparam int BYTES_PER_BLOCK = 1;
  localparam int TREE_DEPTH      = 4;
  localparam int ORAM_DATA_W     = BYTE_WIDTH * BYTES_PER_BLOCK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } host_state_t;

  typedef struct packed {
    logic                   write;
    logic [TREE_DEPTH-1:0]  block;
    logic [ORAM_DATA_W-1:0] wdata;
  } oram_req_t;

endpackage

// File: rtl/oram_host_ctrl_if.sv
// rtl/oram_host_ctrl_if.sv - host request/response channel of the ORAM host controller
interface oram_host_ctrl_if;
  import oramPkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [TREE_DEPTH-1:0]  req_block;
  logic [ORAM_DATA_W-1:0] req_wdata;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [TREE_DEPTH-1:0]  rsp_block;
  logic [ORAM_DATA_W-1:0] rsp_rdata;
  logic                   rsp_timeout;

  // Host side: issues requests, consumes responses
  modport master (
    output req_valid, req_write, req_block, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_block, rsp_rdata, rsp_timeout
  );

  // Controller side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_write, req_block, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_block, rsp_rdata, rsp_timeout
  );

endinterface

// File: rtl/oram_host_ctrl_fifo.sv
// rtl/oram_host_ctrl_fifo.sv - request queue of oram_req_t entries
module oram_req_fifo
  import oramPkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  oram_req_t                i_data,
  input  logic                     i_pop,
  output oram_req_t                o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  oram_req_t         r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/oram_host_ctrl.sv
// rtl/oram_host_ctrl.sv - ORAM initiator: queues host requests, sequences clear/run/response
module oram_host_ctrl
  import oramPkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int CLR_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  oram_host_ctrl_if.slave        host,
  output logic                   o_oram_rst,
  output logic [TREE_DEPTH-1:0]  o_oram_block_num,
  output logic [ORAM_DATA_W-1:0] o_oram_write_val,
  output logic                   o_oram_rw_indicator,
  output logic                   o_oram_input_ready,
  input  logic [ORAM_DATA_W-1:0] i_oram_read_val,
  input  logic                   i_oram_output_ready,
  output logic                   o_busy
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);

  host_state_t            r_state;
  host_state_t            w_next;
  oram_req_t              r_op;
  oram_req_t              w_fifo_data;
  logic                   w_full;
  logic                   w_empty;
  logic [AW:0]            w_count;
  logic                   w_push;
  logic                   w_pop;
  logic [CW-1:0]          r_clr_cnt;
  logic [TW-1:0]          r_to_cnt;
  logic [ORAM_DATA_W-1:0] r_rsp_rdata;
  logic                   r_rsp_timeout;
  logic                   r_rst_hold;
  logic                   w_clr_done;
  logic                   w_done;
  logic                   w_expire;
  logic                   w_rsp_hs;
  logic                   w_drive;

  assign host.req_ready = rst_n && !w_full;
  assign w_push         = host.req_valid && host.req_ready;

  assign w_clr_done = (r_clr_cnt == CW'(CLR_CYCLES - 1));
  assign w_done     = i_oram_output_ready;
  assign w_expire   = TO_EN && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_rsp_hs   = host.rsp_ready;

  oram_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({host.req_write, host.req_block, host.req_wdata}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-state and pop decision; a pop always coincides with entry into CLR
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = CLR;
        end
      end
      CLR: begin
        if (w_clr_done) w_next = RUN;
      end
      RUN: begin
        if (w_done || w_expire) w_next = RESP;
      end
      RESP: begin
        if (w_rsp_hs) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = CLR;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operand latch, phase counters and response capture (completion beats timeout)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= '0;
      r_clr_cnt     <= '0;
      r_to_cnt      <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_rst_hold    <= 1'b1;
    end else begin
      r_rst_hold <= 1'b0;
      if (w_pop) r_op <= w_fifo_data;
      r_clr_cnt <= (r_state == CLR) ? r_clr_cnt + 1'b1 : '0;
      r_to_cnt  <= (r_state == RUN) ? r_to_cnt + 1'b1 : '0;
      if (r_state == RUN) begin
        if (w_done) begin
          r_rsp_rdata   <= r_op.write ? '0 : i_oram_read_val;
          r_rsp_timeout <= 1'b0;
        end else if (w_expire) begin
          r_rsp_rdata   <= '0;
          r_rsp_timeout <= 1'b1;
        end
      end
    end
  end

  // ORAM drive: operands presented from CLR onward, quiet in IDLE
  assign w_drive             = (r_state != IDLE);
  assign o_oram_rst          = r_rst_hold || (r_state == CLR);
  assign o_oram_input_ready  = (r_state == RUN);
  assign o_oram_block_num    = w_drive ? r_op.block : '0;
  assign o_oram_write_val    = w_drive ? r_op.wdata : '0;
  assign o_oram_rw_indicator = w_drive ? r_op.write : 1'b0;

  assign host.rsp_valid   = (r_state == RESP);
  assign host.rsp_write   = r_op.write;
  assign host.rsp_block   = r_op.block;
  assign host.rsp_rdata   = r_rsp_rdata;
  assign host.rsp_timeout = r_rsp_timeout;

  assign o_busy = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_oram_host_ctrl.sv
// tb/tb_oram_host_ctrl.sv - directed self-checking bench for oram_host_ctrl
module tb_oram_host_ctrl;
  import oramPkg::*;

  localparam int CLR_C = 2;
  localparam int TO_C  = 16;
  localparam int MLAT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  oram_host_ctrl_if hif();

  logic       oram_rst;
  logic [3:0] oram_blk;
  logic [7:0] oram_wval;
  logic       oram_rw;
  logic       oram_ir;
  logic [7:0] m_rval;
  logic       m_ordy;
  logic       busy;

  oram_host_ctrl #(
    .FIFO_DEPTH     (4),
    .CLR_CYCLES     (CLR_C),
    .TIMEOUT_CYCLES (TO_C)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .host                (hif),
    .o_oram_rst          (oram_rst),
    .o_oram_block_num    (oram_blk),
    .o_oram_write_val    (oram_wval),
    .o_oram_rw_indicator (oram_rw),
    .o_oram_input_ready  (oram_ir),
    .i_oram_read_val     (m_rval),
    .i_oram_output_ready (m_ordy),
    .o_busy              (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ORAM model: completes MLAT cycles into a request unless stalled
  logic [7:0] m_mem [16];
  int         m_cnt;
  logic       m_stall = 1'b0;
  logic       m_clr   = 1'b0;
  always @(posedge clk) begin
    if (m_clr) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
    end
    if (oram_rst) begin
      m_cnt  <= 0;
      m_ordy <= 1'b0;
      m_rval <= 8'h00;
    end else if (oram_ir && !m_ordy && !m_stall) begin
      if (m_cnt == MLAT - 1) begin
        m_ordy <= 1'b1;
        if (oram_rw) begin
          m_mem[oram_blk] <= oram_wval;
          m_rval <= 8'h00;
        end else begin
          m_rval <= m_mem[oram_blk];
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Clear-pulse monitor: each input_ready rise is preceded by exactly CLR_C reset cycles
  logic mon_en   = 1'b0;
  logic prev_ir  = 1'b0;
  int   rst_run  = 0;
  int   ir_rise  = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (oram_ir && !prev_ir) begin
        check_eq("clr_len", rst_run, CLR_C);
        check_eq("ir_vs_rst", oram_rst, 0);
        ir_rise = cyc;
      end
      if (oram_rst) rst_run++;
      else          rst_run = 0;
      prev_ir = oram_ir;
    end
  end

  task automatic send(input logic w, input logic [3:0] b, input logic [7:0] d);
    int n = 0;
    hif.req_valid = 1'b1;
    hif.req_write = w;
    hif.req_block = b;
    hif.req_wdata = d;
    while (!hif.req_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("req_accept", hif.req_ready, 1);
    @(posedge clk); #1;
    hif.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!hif.rsp_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_valid"}, hif.rsp_valid, 1);
  endtask

  task automatic get_rsp(input string tag, input logic ew, input logic [3:0] eb,
                         input logic [7:0] ed, input logic eto, output int vcyc);
    wait_valid(tag);
    vcyc = cyc;
    check_eq({tag, "_write"},   hif.rsp_write,   ew);
    check_eq({tag, "_block"},   hif.rsp_block,   eb);
    check_eq({tag, "_rdata"},   hif.rsp_rdata,   ed);
    check_eq({tag, "_timeout"}, hif.rsp_timeout, eto);
    hif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    hif.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    int seen;
    hif.req_valid = 1'b0;
    hif.req_write = 1'b0;
    hif.req_block = '0;
    hif.req_wdata = '0;
    hif.rsp_ready = 1'b0;
    m_clr = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_oram_rst", oram_rst, 1);
    check_eq("rst_req_ready", hif.req_ready, 0);
    check_eq("rst_rsp_valid", hif.rsp_valid, 0);
    check_eq("rst_input_ready", oram_ir, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_block_num", oram_blk, 0);
    #20 rst_n = 1'b1;
    #1;
    check_eq("rel_req_ready", hif.req_ready, 1);
    check_eq("rel_oram_rst_held", oram_rst, 1);
    @(posedge clk); #1;
    m_clr = 1'b0;
    check_eq("rel_oram_rst_drop", oram_rst, 0);
    mon_en = 1'b1;

    // Write 2 -> blk1, write 10 -> blk3, read blk1
    send(1'b1, 4'd1, 8'd2);
    send(1'b1, 4'd3, 8'd10);
    send(1'b0, 4'd1, 8'd0);
    get_rsp("seq_w1", 1'b1, 4'd1, 8'd0, 1'b0, vc);
    get_rsp("seq_w3", 1'b1, 4'd3, 8'd0, 1'b0, vc);
    get_rsp("seq_r1", 1'b0, 4'd1, 8'd2, 1'b0, vc);

    // Timeout on a stalled read, then the queued write proceeds
    m_stall = 1'b1;
    send(1'b0, 4'd5, 8'd0);
    send(1'b1, 4'd6, 8'h33);
    get_rsp("to_r5", 1'b0, 4'd5, 8'd0, 1'b1, vc);
    check_eq("to_latency", vc - ir_rise, TO_C);
    m_stall = 1'b0;
    get_rsp("to_next_w6", 1'b1, 4'd6, 8'd0, 1'b0, vc);
    send(1'b0, 4'd6, 8'd0);
    get_rsp("to_next_r6", 1'b0, 4'd6, 8'h33, 1'b0, vc);

    // Response backpressure
    send(1'b1, 4'd7, 8'hA5);
    get_rsp("bp_w7", 1'b1, 4'd7, 8'd0, 1'b0, vc);
    send(1'b0, 4'd7, 8'd0);
    send(1'b1, 4'd2, 8'h11);
    wait_valid("bp_r7");
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_valid", hif.rsp_valid, 1);
      check_eq("bp_hold_rdata", hif.rsp_rdata, 8'hA5);
      check_eq("bp_hold_write", hif.rsp_write, 0);
      check_eq("bp_hold_block", hif.rsp_block, 7);
      check_eq("bp_hold_ir", oram_ir, 0);
      check_eq("bp_hold_rst", oram_rst, 0);
      @(posedge clk); #1;
    end
    get_rsp("bp_r7", 1'b0, 4'd7, 8'hA5, 1'b0, vc);
    get_rsp("bp_next_w2", 1'b1, 4'd2, 8'd0, 1'b0, vc);

    // FIFO full with the ORAM stalled
    m_stall = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 4'(8 + i), 8'(8'h10 + i));
    check_eq("full_req_ready", hif.req_ready, 0);
    check_eq("full_busy", busy, 1);
    m_stall = 1'b0;
    fork
      send(1'b0, 4'd8, 8'd0);
      begin
        int fvc;
        for (int i = 0; i < 5; i++) get_rsp("full_w", 1'b1, 4'(8 + i), 8'd0, 1'b0, fvc);
        get_rsp("full_r8", 1'b0, 4'd8, 8'h10, 1'b0, fvc);
      end
    join

    // Reset during RUN discards in-flight and queued requests
    m_stall = 1'b1;
    send(1'b0, 4'd1, 8'd0);
    send(1'b1, 4'd4, 8'h77);
    seen = 0;
    while (!oram_ir && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    check_eq("mr_in_run", oram_ir, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_ir_async", oram_ir, 0);
    check_eq("mr_rst_async", oram_rst, 1);
    check_eq("mr_rsp_valid", hif.rsp_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_stall = 1'b0;
    @(posedge clk); #1;
    check_eq("mr_busy_after", busy, 0);
    check_eq("mr_oram_rst_after", oram_rst, 0);
    mon_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (hif.rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("mr_no_rsp", seen, 0);
    send(1'b0, 4'd3, 8'd0);
    get_rsp("mr_post_r3", 1'b0, 4'd3, 8'd10, 1'b0, vc);
    send(1'b0, 4'd4, 8'd0);
    get_rsp("mr_post_r4", 1'b0, 4'd4, 8'd0, 1'b0, vc);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oram_host_ctrl.md
Name: oram_host_ctrl

Overview:
Initiator side of the ORAM request interface: the block that drives oram_module's block_num/write_val/rw_indicator/input_ready/rst and consumes its read_val/output_ready. It accepts host read/write requests over a valid/ready channel and queues them in a small FIFO. It sequences each request as a clear-pulse, then a held request, then waits for completion. It returns one in-order response per request, with a timeout flag.

Parameters:
FIFO_DEPTH, 4, request queue entries (power of 2, >=2)
CLR_CYCLES, 1, cycles oram_rst is held high before each operation (>=1)
TIMEOUT_CYCLES, 1024, max cycles in RUN before abort; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  queue can accept (= !full)
req_write  in  1  1=write, 0=read
req_block  in  TREE_DEPTH  block number
req_wdata  in  D  write data, D=BYTE_WIDTH*BYTES_PER_BLOCK
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_write  out  1  echo of request type
rsp_block  out  TREE_DEPTH  echo of block number
rsp_rdata  out  D  read data (0 for writes and timeouts)
rsp_timeout  out  1  operation aborted by timeout
oram_rst  out  1  active-high per-operation reset to ORAM
oram_block_num  out  TREE_DEPTH  to ORAM block_num
oram_write_val  out  D  to ORAM write_val
oram_rw_indicator  out  1  to ORAM rw_indicator
oram_input_ready  out  1  to ORAM input_ready
oram_read_val  in  D  from ORAM read_val
oram_output_ready  in  1  from ORAM output_ready
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n low, async): FIFO emptied and state=IDLE. oram_rst=1; every other output=0, except req_ready, which is 1 once rst_n is high. oram_rst drops on the first clk edge after release.
- FIFO: push on req_valid&&req_ready. Pop only on IDLE->CLR or RESP->CLR transitions. Push and pop in the same cycle leave the count unchanged. No bypass: an entry is visible to the FSM the cycle after its push.
- State IDLE: all oram_* outputs 0. If the FIFO is non-empty, pop the entry into the operand register and go to CLR.
- State CLR: oram_rst=1 and oram_input_ready=0 for exactly CLR_CYCLES cycles. oram_block_num, oram_write_val and oram_rw_indicator are already driven from the operand register. Then go to RUN.
- State RUN: oram_input_ready=1 and operands stable, held until completion. A timeout counter starts at 0 on entry.
  - oram_output_ready==1 sampled in RUN: capture oram_read_val into rsp_rdata if a read, else rsp_rdata=0. rsp_timeout=0. Go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without completion: rsp_rdata=0, rsp_timeout=1, go to RESP.
  - Completion and timeout expiry in the same cycle: completion wins.
- oram_output_ready outside RUN is ignored. This covers stale high levels left over from the previous operation, which are cleared by the CLR pulse.
- State RESP: oram_input_ready=0. rsp_valid=1 with all rsp_* fields stable until rsp_ready. On the handshake: if the FIFO is non-empty, pop and go to CLR; else go to IDLE.
- Latency: push at edge T → CLR at T+1 (IDLE). With ORAM completion L cycles after input_ready rises, rsp_valid rises 1+CLR_CYCLES+L cycles after the push.
- Responses are strictly in request order; exactly one response per accepted request.
- Reset mid-operation: the in-flight request and all queued requests are discarded with no response. oram_input_ready falls immediately and oram_rst rises immediately.

Decomposition:
- oramPkg supplies BYTE_WIDTH, BYTES_PER_BLOCK and TREE_DEPTH.
- Add to oramPkg:
  - ORAM_DATA_W = BYTE_WIDTH*BYTES_PER_BLOCK
  - host_state_t enum {IDLE, CLR, RUN, RESP}
  - oram_req_t packed struct {write, block, wdata}
- One sub-module, oram_req_fifo: synchronous FIFO of oram_req_t with async active-low reset, outputs full/empty/count.

Test Plan:
- Write 2 to block 1, write 10 to block 3, then read block 1, against oram_module → three responses in order, with rsp_write=1,1,0 and read rsp_rdata=2, rsp_timeout=0.
- Check oram_rst per operation → exactly CLR_CYCLES high before each oram_input_ready rise, and oram_input_ready never high while oram_rst is high.
- Timeout: TIMEOUT_CYCLES=16 with a model that never raises output_ready, read block 5 → rsp_timeout=1 and rsp_rdata=0 exactly 16 cycles after RUN entry; the next queued request then proceeds normally.
- Backpressure: hold rsp_ready=0 for 5 cycles on a read returning 0xA5 → rsp_valid and all rsp_* fields stable; the next operation does not start until the handshake.
- FIFO full: 6 back-to-back requests with the ORAM model stalled → req_ready=0 while 4 entries are held, no request lost, 6 responses in order.
- Reset mid-RUN: drop rst_n → oram_input_ready=0 and oram_rst=1 asynchronously, busy=0 after release, no response emitted, a new request completes normally.
